// File: rtl/preproc_ctrl_pkg.sv
// Shared register map, field positions, FSM states and saturation helpers
// for the preprocessing capture controller.
package preproc_ctrl_pkg;

  // Byte addresses of the register port
  localparam int ADDR_CTRL   = 'h0;
  localparam int ADDR_CFG    = 'h4;
  localparam int ADDR_FRAME  = 'h8;
  localparam int ADDR_STATUS = 'hC;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_STOP_BIT  = 1;

  localparam int SEL_LSB    = 0;
  localparam int SEL_W      = 5;
  localparam int OFFSET_LSB = 16;
  localparam int OFFSET_W   = 16;

  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;
  localparam int NUM_LSB = 16;
  localparam int NUM_W   = 16;

  localparam int STS_STATE_LSB   = 0;
  localparam int STS_BUSY_BIT    = 2;
  localparam int STS_DONE_BIT    = 3;
  localparam int STS_OVF_BIT     = 4;
  localparam int STS_SEL_ERR_BIT = 5;
  localparam int STS_PKT_LSB     = 16;
  localparam int PKT_CNT_W       = 16;

  localparam logic [LEN_W-1:0] FRAME_LEN_RST = 16'd1;
  localparam logic [NUM_W-1:0] FRAME_NUM_RST = 16'd10;

  // Guard bits on the offset sum so sample + offset never wraps before clamping
  localparam int SAT_GUARD = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/preproc_offset_sat.sv
// Adds a signed offset to a signed ADC sample and clamps the result to the
// representable ADC_WIDTH range.
module preproc_offset_sat
  import preproc_ctrl_pkg::*;
#(
  parameter int ADC_WIDTH = 14
) (
  input  logic signed [ADC_WIDTH-1:0] sample,
  input  logic signed [OFFSET_W-1:0]  offset,
  output logic signed [ADC_WIDTH-1:0] result
);

  localparam int SUM_W = ADC_WIDTH + SAT_GUARD;
  localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(sat_hi(ADC_WIDTH));
  localparam logic signed [SUM_W-1:0] SUM_LO = SUM_W'(sat_lo(ADC_WIDTH));

  logic signed [SUM_W-1:0] sum;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    sum = SUM_W'(sample) + SUM_W'(offset);
    if (sum > SUM_HI) begin
      result = SUM_HI[ADC_WIDTH-1:0];
    end else if (sum < SUM_LO) begin
      result = SUM_LO[ADC_WIDTH-1:0];
    end else begin
      result = sum[ADC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/preproc_capture_ctrl.sv
// Register-controlled capture of one selected ADC source into a framed
// output stream with offset correction, back-pressure drop and status.
module preproc_capture_ctrl
  import preproc_ctrl_pkg::*;
#(
  parameter int ADC_WIDTH  = 14,
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data,
  input  logic [N_SRC*ADC_WIDTH-1:0]  src_data,
  input  logic [N_SRC-1:0]            src_valid,
  output logic [ADC_WIDTH-1:0]        m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        done
);

  state_e                       state;
  logic [SEL_W-1:0]             cfg_sel, lat_sel;
  logic signed [OFFSET_W-1:0]   cfg_offset, lat_offset;
  logic [LEN_W-1:0]             frame_len, eff_len, samp_cnt;
  logic [NUM_W-1:0]             frame_num, prod_cnt;
  logic [PKT_CNT_W-1:0]         pkt_cnt;
  logic                         ovf, sel_err;

  logic                         wr_ctrl, start_req, stop_req;
  logic signed [ADC_WIDTH-1:0]  sel_sample, sat_data;
  logic                         sel_valid, sel_ok;
  logic                         is_last, last_pkt, stall, xfer, take, accept, drop, lat_load;
  logic [DATA_WIDTH-1:0]        cfg_word, frame_word, status_word;

  // Stop in the same write as start wins, so start is masked by stop here
  assign wr_ctrl   = wr_en && (wr_addr == ADDR_WIDTH'(ADDR_CTRL));
  assign stop_req  = wr_ctrl && wr_data[CTRL_STOP_BIT];
  assign start_req = wr_ctrl && wr_data[CTRL_START_BIT] && !wr_data[CTRL_STOP_BIT];

  always_comb begin
    sel_sample = '0;
    sel_valid  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (lat_sel == SEL_W'(k)) begin
        sel_sample = src_data[k*ADC_WIDTH +: ADC_WIDTH];
        sel_valid  = src_valid[k];
      end
    end
  end

  assign sel_ok   = (lat_sel < SEL_W'(N_SRC));
  assign eff_len  = (frame_len == '0) ? LEN_W'(1) : frame_len;
  assign is_last  = (samp_cnt == LEN_W'(eff_len - 1'b1));
  assign last_pkt = (frame_num != '0) && (prod_cnt == NUM_W'(frame_num - 1'b1));

  assign stall  = m_valid && !m_ready;
  assign xfer   = m_valid && m_ready;
  assign take   = (state == ST_RUN) && sel_ok && sel_valid;
  assign accept = take && !stall;
  assign drop   = take && stall;
  // Source/offset track CFG only between packets; frozen once a packet has begun
  assign lat_load = (accept && is_last) || (!accept && (samp_cnt == '0));

  preproc_offset_sat #(
    .ADC_WIDTH(ADC_WIDTH)
  ) u_offset_sat (
    .sample(sel_sample),
    .offset(lat_offset),
    .result(sat_data)
  );

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_sel    <= '0;
      cfg_offset <= '0;
      frame_len  <= FRAME_LEN_RST;
      frame_num  <= FRAME_NUM_RST;
    end else if (wr_en) begin
      if (wr_addr == ADDR_WIDTH'(ADDR_CFG)) begin
        cfg_sel    <= wr_data[SEL_LSB +: SEL_W];
        cfg_offset <= wr_data[OFFSET_LSB +: OFFSET_W];
      end
      if ((wr_addr == ADDR_WIDTH'(ADDR_FRAME)) && !busy) begin
        frame_len <= wr_data[LEN_LSB +: LEN_W];
        frame_num <= wr_data[NUM_LSB +: NUM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_data     <= '0;
      samp_cnt   <= '0;
      prod_cnt   <= '0;
      pkt_cnt    <= '0;
      ovf        <= 1'b0;
      sel_err    <= 1'b0;
      lat_sel    <= '0;
      lat_offset <= '0;
    end else begin
      if (xfer && m_last) pkt_cnt <= pkt_cnt + 1'b1;

      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_req) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            samp_cnt   <= '0;
            prod_cnt   <= '0;
            pkt_cnt    <= '0;
            ovf        <= 1'b0;
            sel_err    <= 1'b0;
            lat_sel    <= cfg_sel;
            lat_offset <= cfg_offset;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
          end
        end

        ST_RUN: begin
          if (stop_req) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end else begin
            if (!sel_ok) sel_err <= 1'b1;
            if (drop)    ovf     <= 1'b1;
            if (lat_load) begin
              lat_sel    <= cfg_sel;
              lat_offset <= cfg_offset;
            end
            if (accept) begin
              m_valid <= 1'b1;
              m_data  <= sat_data;
              m_last  <= is_last;
              if (is_last) begin
                samp_cnt <= '0;
                prod_cnt <= prod_cnt + 1'b1;
                if (last_pkt) state <= ST_DRAIN;
              end else begin
                samp_cnt <= samp_cnt + 1'b1;
              end
            end else if (xfer) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
          end
        end

        ST_DRAIN: begin
          if (stop_req) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end else if (xfer) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cfg_word    = '0;
    frame_word  = '0;
    status_word = '0;
    cfg_word[SEL_LSB +: SEL_W]        = cfg_sel;
    cfg_word[OFFSET_LSB +: OFFSET_W]  = cfg_offset;
    frame_word[LEN_LSB +: LEN_W]      = frame_len;
    frame_word[NUM_LSB +: NUM_W]      = frame_num;
    status_word[STS_STATE_LSB +: 2]   = state;
    status_word[STS_BUSY_BIT]         = busy;
    status_word[STS_DONE_BIT]         = done;
    status_word[STS_OVF_BIT]          = ovf;
    status_word[STS_SEL_ERR_BIT]      = sel_err;
    status_word[STS_PKT_LSB +: PKT_CNT_W] = pkt_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      unique case (rd_addr)
        ADDR_WIDTH'(ADDR_CFG):    rd_data <= cfg_word;
        ADDR_WIDTH'(ADDR_FRAME):  rd_data <= frame_word;
        ADDR_WIDTH'(ADDR_STATUS): rd_data <= status_word;
        default:                  rd_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_preproc_capture_ctrl.sv
// Directed self-checking bench for preproc_capture_ctrl: framing, offset
// saturation, back-pressure drop, source errors, stop and reset behaviour.
module tb_preproc_capture_ctrl;

  localparam int ADC_WIDTH  = 14;
  localparam int N_SRC      = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        wr_en;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic [ADDR_WIDTH-1:0]       rd_addr;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic [N_SRC*ADC_WIDTH-1:0]  src_data;
  logic [N_SRC-1:0]            src_valid;
  logic [ADC_WIDTH-1:0]        m_data;
  logic                        m_valid, m_last, m_ready, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  preproc_capture_ctrl #(
    .ADC_WIDTH(ADC_WIDTH), .N_SRC(N_SRC), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .src_data(src_data), .src_valid(src_valid),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a;
    tick();
    check(tag, rd_data, exp);
  endtask

  task automatic set_src(input int k, input logic [13:0] v);
    src_data[k*ADC_WIDTH +: ADC_WIDTH] = v;
  endtask

  initial begin
    int nb, nl;
    logic found;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    src_data = '0; src_valid = '0; m_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_m_data", m_data, 0);
    rd_check("rst_frame", 4'h8, 32'h000A0001);
    rd_check("rst_cfg", 4'h4, 32'h0);
    rd_check("rst_status", 4'hC, 32'h0);

    // Two packets of four from source 1, offset 0
    wr(4'h8, 32'h0002_0004);
    wr(4'h4, 32'h0000_0001);
    src_valid = 4'b0010;
    wr(4'h0, 32'h1);
    nb = 0;
    for (int c = 1; c <= 20; c++) begin
      set_src(1, 14'(c));
      tick();
      if (m_valid) begin
        nb++;
        check("frm_data", m_data, 32'(nb));
        check("frm_last", m_last, (nb % 4 == 0) ? 1 : 0);
      end
    end
    check("frm_beats", nb, 8);
    check("frm_done", done, 1);
    check("frm_busy", busy, 0);
    rd_check("frm_status", 4'hC, 32'h0002_000B);

    // Saturation at both rails, plus one in-range negative result
    src_valid = 4'b0001;
    wr(4'h8, 32'h0001_0001);
    wr(4'h4, 32'h0064_0000);
    set_src(0, 14'd8150);
    wr(4'h0, 32'h1);
    tick();
    check("sat_hi_valid", m_valid, 1);
    check("sat_hi_data", m_data, 32'h1FFF);
    check("sat_hi_last", m_last, 1);
    repeat (2) tick();
    wr(4'h4, 32'hFF9C_0000);
    set_src(0, 14'h202A);
    wr(4'h0, 32'h1);
    tick();
    check("sat_lo_data", m_data, 32'h2000);
    repeat (2) tick();
    set_src(0, 14'd50);
    wr(4'h0, 32'h1);
    tick();
    check("off_neg_data", m_data, 32'h3FCE);
    repeat (2) tick();

    // Back-pressure: first beat held, three samples dropped, ovf set
    wr(4'h4, 32'h0);
    wr(4'h8, 32'h0001_0008);
    m_ready = 1'b0;
    set_src(0, 14'd21);
    wr(4'h0, 32'h1);
    tick();
    check("bp_first_valid", m_valid, 1);
    check("bp_first_data", m_data, 21);
    for (int k = 22; k <= 24; k++) begin
      set_src(0, 14'(k));
      tick();
      check("bp_hold_valid", m_valid, 1);
      check("bp_hold_data", m_data, 21);
    end
    set_src(0, 14'd25);
    m_ready = 1'b1;
    tick();
    check("bp_next_data", m_data, 25);
    src_valid = '0;
    tick();
    rd_check("bp_status", 4'hC, 32'h0000_0015);
    wr(4'h0, 32'h2);
    check("bp_stop_busy", busy, 0);
    rd_check("bp_status_idle", 4'hC, 32'h0000_0010);

    // Out-of-range source, then recovery on source 2
    wr(4'h4, 32'h7);
    wr(4'h8, 32'h0001_0002);
    src_data  = {14'd13, 14'd12, 14'd11, 14'd10};
    src_valid = 4'b1111;
    wr(4'h0, 32'h1);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_valid) nb++;
    end
    check("selerr_no_valid", nb, 0);
    rd_check("selerr_status", 4'hC, 32'h0000_0025);
    wr(4'h8, 32'h1234_5678);
    rd_check("frame_locked", 4'h8, 32'h0001_0002);
    wr(4'h4, 32'h2);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (m_valid) found = 1'b1;
    end
    check("selerr_resume", found, 1);
    check("selerr_resume_data", m_data, 12);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    check("selerr_done", found, 1);
    rd_check("selerr_status_done", 4'hC, 32'h0001_002B);

    // Stop mid packet 2 of 3
    wr(4'h4, 32'h0);
    wr(4'h8, 32'h0003_0004);
    src_valid = 4'b0001;
    set_src(0, 14'd7);
    wr(4'h0, 32'h1);
    repeat (5) tick();
    check("stop_pre_valid", m_valid, 1);
    wr(4'h0, 32'h2);
    check("stop_valid", m_valid, 0);
    check("stop_busy", busy, 0);
    check("stop_done", done, 0);
    src_valid = '0;
    rd_check("stop_status", 4'hC, 32'h0001_0000);

    // Start and stop together: stop wins
    wr(4'h0, 32'h3);
    check("startstop_busy", busy, 0);
    rd_check("startstop_status", 4'hC, 32'h0001_0000);

    // pkt_len 0 behaves as 1
    wr(4'h8, 32'h0002_0000);
    src_valid = 4'b0001;
    set_src(0, 14'd5);
    wr(4'h0, 32'h1);
    nb = 0; nl = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_valid) begin
        nb++;
        if (m_last) nl++;
      end
    end
    check("len0_beats", nb, 2);
    check("len0_lasts", nl, 2);
    check("len0_done", done, 1);

    // Reset in the middle of a packet
    wr(4'h4, 32'h0064_0001);
    wr(4'h8, 32'h0005_0003);
    src_valid = 4'b0010;
    set_src(1, 14'd200);
    wr(4'h0, 32'h1);
    repeat (2) tick();
    check("mid_valid", m_valid, 1);
    check("mid_data", m_data, 300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", m_valid, 0);
    check("mrst_last", m_last, 0);
    check("mrst_data", m_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    rd_check("mrst_status", 4'hC, 32'h0);
    rd_check("mrst_frame", 4'h8, 32'h000A_0001);
    rd_check("mrst_cfg", 4'h4, 32'h0);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_valid) nb++;
    end
    check("mrst_idle_quiet", nb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/preproc_capture_ctrl.md
PREPROC_CAPTURE_CTRL -- requirements
Module: preproc_capture_ctrl

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 14, sample width (signed two's complement).
REQ-002 SHALL have parameter N_SRC, default 4, number of selectable sample sources.
REQ-003 SHALL have parameters DATA_WIDTH, default 32, and ADDR_WIDTH, default 4, for the register port.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports wr_en/wr_addr/wr_data  input  1/ADDR_WIDTH/DATA_WIDTH  register write, one write per asserted cycle.
REQ-007 SHALL have ports rd_addr input ADDR_WIDTH and rd_data output DATA_WIDTH  register readback.
REQ-008 SHALL have ports src_data input N_SRC*ADC_WIDTH and src_valid input N_SRC  per-source sample streams (source k in slice k).
REQ-009 SHALL have ports m_data output ADC_WIDTH, m_valid output 1, m_last output 1, m_ready input 1  framed output stream.
REQ-010 SHALL have ports busy output 1 and done output 1  capture status.

Function
REQ-011 SHALL decode byte addresses: 0x0 CTRL (bit0 start, bit1 stop, write-only pulses), 0x4 CFG (bits[4:0] sel_source, bits[31:16] offset, signed), 0x8 FRAME (bits[15:0] pkt_len, bits[31:16] pkt_num), 0xC STATUS (read-only).
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE/DONE -> RUN on start; pkt_cnt and sample counter cleared; done cleared.
REQ-014 SHALL latch sel_source and offset at start of every packet; CFG writes mid-packet take effect at the next packet.
REQ-015 SHALL ignore FRAME writes while busy; pkt_len 0 SHALL be treated as 1; pkt_num 0 means continuous until stop.
REQ-016 In RUN, a src_valid pulse on the latched source SHALL produce m_valid one cycle later with m_data = saturate(sample + offset) to [-2^(ADC_WIDTH-1), 2^(ADC_WIDTH-1)-1], sum computed at ADC_WIDTH+3 bits.
REQ-017 m_valid/m_data/m_last SHALL hold until m_valid && m_ready; transfer occurs on that cycle.
REQ-018 A source sample arriving while m_valid && !m_ready SHALL be dropped, not counted, and set sticky ovf.
REQ-019 m_last SHALL assert on sample pkt_len of each packet; pkt_cnt increments when that beat transfers.
REQ-020 When the last beat of packet pkt_num is produced, SHALL enter DRAIN; DRAIN -> DONE when it transfers; done=1 in DONE.
REQ-021 sel_source >= N_SRC SHALL set sticky sel_err and generate no output samples while latched.
REQ-022 stop in RUN/DRAIN SHALL go to IDLE next cycle, deassert m_valid, keep pkt_cnt; start and stop in same write: stop wins.
REQ-023 STATUS SHALL read {pkt_cnt[15:0], 10'b0, sel_err, ovf, done, busy, state[1:0]}; ovf/sel_err cleared on start.
REQ-024 rd_data SHALL be registered, valid one cycle after rd_addr; unmapped addresses read 0.
REQ-025 busy SHALL be 1 in RUN and DRAIN only.
REQ-026 pkt_cnt SHALL wrap at 2^16 in continuous mode without affecting framing.

Reset
REQ-027 On rst SHALL enter IDLE; m_valid, m_last, busy, done, ovf, sel_err, pkt_cnt, rd_data = 0; m_data = 0.
REQ-028 On rst, CFG = 0 (source 0, offset 0) and FRAME = {pkt_num 10, pkt_len 1}.
REQ-029 rst mid-packet SHALL abandon the packet with no m_last emitted.

Structure
REQ-030 Register addresses, field positions, state enum and saturation bounds SHALL live in a shared preproc_ctrl_pkg package.
REQ-031 Offset-add-and-saturate SHALL be a sub-module, preproc_offset_sat, combinational, ADC_WIDTH-parameterised.
REQ-032 Register file, source mux and framing FSM SHALL remain in preproc_capture_ctrl.

Verification
REQ-033 FRAME pkt_len=4, pkt_num=2, source 1 continuous valid, m_ready=1 -> 8 beats, m_last on beats 4 and 8, done=1, pkt_cnt=2.
REQ-034 offset=+100, sample 8150 -> m_data 8191; offset=-100, sample -8150 -> m_data -8192.
REQ-035 m_ready=0 for 3 cycles with valid every cycle -> first beat held stable, 3 samples dropped, ovf=1.
REQ-036 sel_source=7 with N_SRC=4 -> sel_err=1, m_valid never asserts; rewrite to 2 -> output resumes next packet.
REQ-037 stop written mid-packet 2 of 3 -> IDLE next cycle, m_valid=0, pkt_cnt=1, done=0.
REQ-038 rst asserted in RUN for one cycle -> all outputs and STATUS read 0, FRAME reads 0x000A0001.
